fround_pipe: RTL and testbench

- Pipelined IEEE-754 binary32 round-to-integral unit. It is the parametrised successor to the team's combinational floor block.
- Supports four rounding modes: floor, ceil, trunc and round-to-nearest-even.
- Produces two results per operation: the rounded float and a saturated signed 32-bit integer (ftoi).
- Sits in the FPU behind the issue stage. It uses a valid/ready handshake so the core can stall it.

---
 rtl/fround_if.sv | 30 +++
 rtl/fround_pipe.sv | 195 +++++++++++++++++++
 tb/tb_fround_pipe.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fround_if.sv
// Operand/result bundle for the round-to-integral pipe.
//
// Handshake: a beat moves on any rising clock edge where valid and ready are
// both high (in_valid/in_ready for operands, out_valid/out_ready for results).
// The producer holds its payload stable while valid is high and ready is low.
// in_ready never depends combinationally on in_valid.
interface fround_if;
    logic [31:0] src;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dest;
    logic [31:0] dest_int;
    logic        inexact;
    logic        invalid;
    logic        out_valid;
    logic        out_ready;

    // Issue side / consumer side of the FPU
    modport master (
        output src, mode, in_valid, out_ready,
        input  in_ready, dest, dest_int, inexact, invalid, out_valid
    );

    // The rounding unit itself
    modport slave (
        input  src, mode, in_valid, out_ready,
        output in_ready, dest, dest_int, inexact, invalid, out_valid
    );
endinterface

// File: rtl/fround_pipe.sv
// Pipelined binary32 round-to-integral with saturated integer conversion.
// The rounding datapath is evaluated on the incoming operand; the result then
// travels through STAGES elastic registers whose bubbles collapse.
// Modes: 00 round-nearest-even, 01 trunc, 10 floor, 11 ceil.
module fround_pipe #(
    parameter int STAGES       = 2,
    parameter bit FLUSH_DENORM = 1'b1
) (
    input logic     clk,
    input logic     rst,
    fround_if.slave bus
);

    generate
        if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
            $error("fround_pipe: STAGES must be in 1..3");
        end
    endgenerate

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [30:0] ONE_MAG = 31'h3F80_0000;

    typedef struct packed {
        logic [31:0] dest;
        logic [31:0] dest_int;
        logic        inexact;
        logic        invalid;
    } result_t;

    // Operand fields
    logic        sgn;
    logic [7:0]  ex;
    logic [22:0] fr;

    assign sgn = bus.src[31];
    assign ex  = bus.src[30:23];
    assign fr  = bus.src[22:0];

    logic is_nan, is_inf, is_zero;

    // Classify special encodings
    always_comb begin
        is_nan  = (ex == 8'hFF) && (fr != '0);
        is_inf  = (ex == 8'hFF) && (fr == '0);
        is_zero = (ex == 8'h00) && (FLUSH_DENORM || (fr == '0));
    end

    // Fraction split and increment for 0 <= e <= 22 (biased exponent 127..149)
    logic [4:0]  sh;
    logic [22:0] mask;
    logic [23:0] mant;
    logic        half, sticky, lsb, frac_nz, inc;
    logic [30:0] mag_trunc, mag_sum;

    always_comb begin
        sh        = 5'(8'd150 - ex);
        mask      = (23'd1 << sh) - 23'd1;
        mant      = {1'b1, fr};
        frac_nz   = |(fr & mask);
        half      = mant[sh - 5'd1];
        sticky    = |(fr & (mask >> 1));
        lsb       = mant[sh];
        case (bus.mode)
            2'b00:   inc = half && (sticky || lsb);
            2'b01:   inc = 1'b0;
            2'b10:   inc = sgn && frac_nz;
            default: inc = !sgn && frac_nz;
        endcase
        mag_trunc = {ex, fr & ~mask};
        // A carry out of the mantissa lands in the exponent, which is the
        // correct encoding of the next power of two.
        mag_sum   = mag_trunc + (31'd1 << sh);
    end

    logic [31:0] r_dest;
    logic        r_inexact;

    // Pick the rounded float for each input class
    always_comb begin
        r_dest    = bus.src;
        r_inexact = 1'b0;
        if (is_nan) begin
            r_dest = QNAN;
        end else if (is_inf) begin
            r_dest = bus.src;
        end else if (is_zero) begin
            r_dest = {sgn, 31'd0};
        end else if (ex >= 8'd150) begin
            r_dest = bus.src;
        end else if (ex >= 8'd127) begin
            r_dest    = {sgn, inc ? mag_sum : mag_trunc};
            r_inexact = frac_nz;
        end else begin
            // Nonzero magnitude below one: result is a signed zero or one.
            r_inexact = 1'b1;
            case (bus.mode)
                2'b00:   r_dest = {sgn, ((ex == 8'd126) && (fr != '0)) ? ONE_MAG : 31'd0};
                2'b01:   r_dest = {sgn, 31'd0};
                2'b10:   r_dest = sgn ? {1'b1, ONE_MAG} : 32'h0000_0000;
                default: r_dest = sgn ? 32'h8000_0000 : {1'b0, ONE_MAG};
            endcase
        end
    end

    logic [7:0]  dex;
    logic [31:0] dmag;
    logic [31:0] r_int;
    logic        r_invalid;

    // Convert the rounded float (already integral) to a saturated int32
    always_comb begin
        dex       = r_dest[30:23];
        dmag      = '0;
        r_int     = '0;
        r_invalid = 1'b0;
        if (is_nan) begin
            r_int     = 32'h7FFF_FFFF;
            r_invalid = 1'b1;
        end else if (dex >= 8'd158) begin
            // |dest| >= 2^31; only -2^31 itself is representable.
            if (r_dest == 32'hCF00_0000) begin
                r_int = 32'h8000_0000;
            end else begin
                r_int     = r_dest[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                r_invalid = 1'b1;
            end
        end else if (dex >= 8'd127) begin
            if (dex >= 8'd150) begin
                dmag = {8'd0, 1'b1, r_dest[22:0]} << (dex - 8'd150);
            end else begin
                dmag = {8'd0, 1'b1, r_dest[22:0]} >> (8'd150 - dex);
            end
            r_int = r_dest[31] ? -dmag : dmag;
        end
    end

    result_t res;
    assign res = {r_dest, r_int, r_inexact, r_invalid};

    // Elastic pipeline state
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] vin;
    result_t           pay [STAGES];
    result_t           pin [STAGES];

    // A stage may load when it or any stage after it has a hole, or when the
    // consumer takes the head; this lets bubbles collapse.
    always_comb begin
        logic go;
        go  = bus.out_ready;
        rdy = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            go     = go || !vld[i];
            rdy[i] = go;
        end
    end

    // What each stage would load: the new result or its predecessor
    always_comb begin
        vin[0] = bus.in_valid;
        pin[0] = res;
        for (int i = 1; i < STAGES; i++) begin
            vin[i] = vld[i-1];
            pin[i] = pay[i-1];
        end
    end

    // Stage registers; payload only updates when a real op moves in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < STAGES; i++) begin
                pay[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (rdy[i]) begin
                    vld[i] <= vin[i];
                    if (vin[i]) begin
                        pay[i] <= pin[i];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = vld[STAGES-1];
    assign bus.dest      = pay[STAGES-1].dest;
    assign bus.dest_int  = pay[STAGES-1].dest_int;
    assign bus.inexact   = pay[STAGES-1].inexact;
    assign bus.invalid   = pay[STAGES-1].invalid;

endmodule

// File: tb/tb_fround_pipe.sv
// Bench for fround_pipe: three instances (STAGES = 1, 2, 3) fed the same
// operand stream, each with its own pending queue and expected queue.
module tb_fround_pipe;

    localparam bit FLUSH = 1'b1;
    localparam int ND    = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0]   src_d  [ND];
    logic [1:0]    mode_d [ND];
    logic [ND-1:0] iv;
    logic          ordy;
    logic [ND-1:0] ir, ov, inx, inv;
    logic [31:0]   dst    [ND];
    logic [31:0]   dint   [ND];

    generate
        for (genvar g = 0; g < ND; g++) begin : g_dut
            fround_if bus();
            assign bus.src       = src_d[g];
            assign bus.mode      = mode_d[g];
            assign bus.in_valid  = iv[g];
            assign bus.out_ready = ordy;
            assign ir[g]         = bus.in_ready;
            assign ov[g]         = bus.out_valid;
            assign dst[g]        = bus.dest;
            assign dint[g]       = bus.dest_int;
            assign inx[g]        = bus.inexact;
            assign inv[g]        = bus.invalid;

            fround_pipe #(.STAGES(g + 1), .FLUSH_DENORM(FLUSH)) dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );
        end
    endgenerate

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [31:0] src;
        logic [1:0]  mode;
        logic [65:0] exp;
    } op_t;

    op_t         pend_q [ND][$];
    logic [65:0] exp_q  [ND][$];   // {dest, dest_int, inexact, invalid}
    int          acc_q  [ND][$];   // cycle at which each op was accepted
    logic [ND-1:0] hold_v;
    logic [65:0] hold_val [ND];
    int cyc, n_checks, n_fail;
    bit rand_ready, rand_gap;

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] enc_int(input real r, input logic s);
        int unsigned mag;
        int          p;
        logic [31:0] m;
        if (r == 0.0) return {s, 31'd0};
        mag = $rtoi(r < 0.0 ? -r : r);
        p = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) p = i;
        m = mag << (23 - p);
        return {(r < 0.0) ? 1'b1 : 1'b0, 8'(127 + p), m[22:0]};
    endfunction

    function automatic logic [65:0] model(input logic [31:0] a, input logic [1:0] m);
        logic        s;
        logic [7:0]  ex;
        logic [22:0] fr;
        real         x, r, fl, d, lim;
        logic [31:0] dv, ival;
        logic        nx, nv;
        s   = a[31];
        ex  = a[30:23];
        fr  = a[22:0];
        lim = 2.0 ** 31.0;
        if (ex == 8'hFF) begin
            if (fr != 0) return {32'h7FC0_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
            return {a, s ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b0, 1'b1};
        end
        if (ex == 8'h00 && (FLUSH || fr == 0)) return {{s, 31'd0}, 32'd0, 1'b0, 1'b0};
        if (ex == 8'h00) x = real'(fr) * (2.0 ** -149.0);
        else x = (1.0 + real'(fr) / 8388608.0) * (2.0 ** (real'(int'(ex)) - 127.0));
        if (s) x = -x;
        if (ex >= 8'd150) begin
            r  = x;
            dv = a;
        end else begin
            case (m)
                2'b00: begin
                    fl = $floor(x);
                    d  = x - fl;
                    if (d > 0.5) r = fl + 1.0;
                    else if (d < 0.5) r = fl;
                    else r = ((fl / 2.0) == $floor(fl / 2.0)) ? fl : fl + 1.0;
                end
                2'b01:   r = (x < 0.0) ? $ceil(x) : $floor(x);
                2'b10:   r = $floor(x);
                default: r = $ceil(x);
            endcase
            dv = enc_int(r, s);
        end
        nx = (r != x);
        if (r >= lim) begin
            ival = 32'h7FFF_FFFF;
            nv   = 1'b1;
        end else if (r < -lim) begin
            ival = 32'h8000_0000;
            nv   = 1'b1;
        end else begin
            ival = $rtoi(r);
            nv   = 1'b0;
        end
        return {dv, ival, nx, nv};
    endfunction

    function automatic logic [31:0] rand_src();
        logic [7:0] ex;
        int sel;
        sel = $urandom_range(0, 15);
        if (sel == 0) ex = 8'hFF;
        else if (sel == 1) ex = 8'h00;
        else if (sel < 6) ex = 8'($urandom_range(1, 254));
        else ex = 8'($urandom_range(118, 160));
        return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_op(input logic [31:0] a, input logic [1:0] m, input logic [65:0] e);
        op_t op;
        op.src  = a;
        op.mode = m;
        op.exp  = e;
        for (int k = 0; k < ND; k++) pend_q[k].push_back(op);
    endtask

    task automatic push_rand();
        logic [31:0] a;
        logic [1:0]  m;
        a = rand_src();
        m = 2'($urandom_range(0, 3));
        push_op(a, m, model(a, m));
    endtask

    // One clock: drive after the edge, check and track at the falling edge.
    task automatic tick();
        logic [65:0] got, e;
        bit exp_rdy, exp_ov;
        for (int k = 0; k < ND; k++) begin
            if (pend_q[k].size() > 0 && !(rand_gap && $urandom_range(0, 4) == 0)) begin
                iv[k]     = 1'b1;
                src_d[k]  = pend_q[k][0].src;
                mode_d[k] = pend_q[k][0].mode;
            end else begin
                iv[k] = 1'b0;
            end
        end
        if (rand_ready) ordy = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        cyc++;
        for (int k = 0; k < ND; k++) begin
            got     = {dst[k], dint[k], inx[k], inv[k]};
            exp_rdy = ordy || (exp_q[k].size() < k + 1);
            exp_ov  = (exp_q[k].size() > 0) && (cyc - acc_q[k][0] >= k + 1);
            check($sformatf("S%0d in_ready", k + 1), 66'(ir[k]), 66'(exp_rdy));
            check($sformatf("S%0d out_valid", k + 1), 66'(ov[k]), 66'(exp_ov));
            if (hold_v[k]) check($sformatf("S%0d hold", k + 1), got, hold_val[k]);
            if (ov[k] && ordy && exp_q[k].size() > 0) begin
                e = exp_q[k].pop_front();
                void'(acc_q[k].pop_front());
                check($sformatf("S%0d dest", k + 1), 66'(dst[k]), 66'(e[65:34]));
                check($sformatf("S%0d dest_int", k + 1), 66'(dint[k]), 66'(e[33:2]));
                check($sformatf("S%0d flags", k + 1), 66'({inx[k], inv[k]}), 66'(e[1:0]));
            end
            hold_v[k]   = ov[k] && !ordy;
            hold_val[k] = got;
            if (iv[k] && ir[k]) begin
                exp_q[k].push_back(pend_q[k][0].exp);
                acc_q[k].push_back(cyc);
                void'(pend_q[k].pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic int left();
        int n;
        n = 0;
        for (int k = 0; k < ND; k++) n += pend_q[k].size() + exp_q[k].size();
        return n;
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (left() > 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 66'(left()), 66'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst        = 1'b1;
        iv         = '0;
        ordy       = 1'b1;
        rand_ready = 1'b0;
        rand_gap   = 1'b0;
        hold_v     = '0;
        cyc        = 0;
        n_checks   = 0;
        n_fail     = 0;
        for (int k = 0; k < ND; k++) begin
            src_d[k]  = '0;
            mode_d[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < ND; k++) begin
            check($sformatf("S%0d reset out", k + 1),
                  66'({dst[k], dint[k], inx[k], inv[k]}), 66'(0));
            check($sformatf("S%0d reset out_valid", k + 1), 66'(ov[k]), 66'(0));
            check($sformatf("S%0d reset in_ready", k + 1), 66'(ir[k]), 66'(1));
        end
        rst = 1'b0;

        // Directed vectors: src, mode, {dest, dest_int, inexact, invalid}
        push_op(32'hBFC0_0000, 2'b10, {32'hC000_0000, 32'hFFFF_FFFE, 1'b1, 1'b0});
        push_op(32'h4020_0000, 2'b00, {32'h4000_0000, 32'h0000_0002, 1'b1, 1'b0});
        push_op(32'h4060_0000, 2'b00, {32'h4080_0000, 32'h0000_0004, 1'b1, 1'b0});
        push_op(32'h3F00_0000, 2'b00, {32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0});
        push_op(32'h3E99_999A, 2'b11, {32'h3F80_0000, 32'h0000_0001, 1'b1, 1'b0});
        push_op(32'h3E99_999A, 2'b10, {32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0});
        push_op(32'hBE99_999A, 2'b10, {32'hBF80_0000, 32'hFFFF_FFFF, 1'b1, 1'b0});
        push_op(32'hBE99_999A, 2'b01, {32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0});
        push_op(32'h3FFF_FFFF, 2'b11, {32'h4000_0000, 32'h0000_0002, 1'b1, 1'b0});
        push_op(32'h4F00_0000, 2'b01, {32'h4F00_0000, 32'h7FFF_FFFF, 1'b0, 1'b1});
        push_op(32'hCF00_0000, 2'b01, {32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0});
        push_op(32'h7FA0_0000, 2'b00, {32'h7FC0_0000, 32'h7FFF_FFFF, 1'b0, 1'b1});
        push_op(32'hFF80_0000, 2'b10, {32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b1});
        push_op(32'hBF00_0000, 2'b00, {32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0});
        push_op(32'h0040_0000, 2'b11, {32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0});
        drain(200);

        // Backpressure: six back-to-back ops, consumer stalls cycles 3..6
        for (int i = 0; i < 6; i++) push_rand();
        for (int t = 1; t <= 10; t++) begin
            ordy = !(t >= 3 && t <= 6);
            tick();
        end
        ordy = 1'b1;
        drain(200);

        // Reset with ops in flight
        ordy = 1'b0;
        push_rand();
        push_rand();
        tick();
        tick();
        rst = 1'b1;
        #1;
        for (int k = 0; k < ND; k++) begin
            check($sformatf("S%0d midreset out_valid", k + 1), 66'(ov[k]), 66'(0));
            check($sformatf("S%0d midreset in_ready", k + 1), 66'(ir[k]), 66'(1));
            pend_q[k].delete();
            exp_q[k].delete();
            acc_q[k].delete();
        end
        hold_v = '0;
        iv     = '0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        ordy = 1'b1;
        repeat (8) tick();

        // Random regression with random gaps and backpressure
        rand_ready = 1'b1;
        rand_gap   = 1'b1;
        for (int i = 0; i < 400; i++) push_rand();
        drain(5000);

        // Full-throughput streaming
        rand_ready = 1'b0;
        rand_gap   = 1'b0;
        ordy       = 1'b1;
        for (int i = 0; i < 60; i++) push_rand();
        drain(500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
